// File: rtl/data_unpack_unit_if.sv
// Packed-word in / operand-pair out handshake bundle for data_unpack_unit.
interface data_unpack_unit_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                       data_valid;
    logic [2*WIDTH*DEPTH-1:0]   data_in;
    logic                       in_ready;
    logic [WIDTH-1:0]           data_out1;
    logic [WIDTH-1:0]           data_out2;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    modport master (
        output data_valid, data_in, out_ready,
        input  in_ready, data_out1, data_out2, out_valid, out_last
    );

    modport slave (
        input  data_valid, data_in, out_ready,
        output in_ready, data_out1, data_out2, out_valid, out_last
    );
endinterface

// File: rtl/data_unpack_unit.sv
// Buffers one packed word and emits its DEPTH lanes as (lo, hi) operand pairs.
// Optional DATA_UNPACK_PRELOAD_EN: accept the next word on the last beat (no bubble).
module data_unpack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    data_unpack_unit_if.slave  bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = 2 * WIDTH;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state;
    logic [DEPTH-1:0][LW-1:0] lane_buf;
    logic [IW-1:0]            idx;
    logic [LW-1:0]            cur_lane;
    logic                     last_lane;
    logic                     in_hs;
    logic                     beat;

    assign last_lane = (idx == IW'(DEPTH - 1));
    assign cur_lane  = lane_buf[idx];

`ifdef DATA_UNPACK_PRELOAD_EN
    assign bus.in_ready = en && !rst &&
                          ((state == IDLE) || ((state == SEND) && last_lane && bus.out_ready));
`else
    assign bus.in_ready = en && !rst && (state == IDLE);
`endif

    // Outputs come only from the registered buffer and index, never from data_in.
    assign bus.out_valid = en && !rst && (state == SEND);
    assign bus.out_last  = bus.out_valid && last_lane;
    assign bus.data_out1 = cur_lane[WIDTH-1:0];
    assign bus.data_out2 = cur_lane[LW-1:WIDTH];

    assign in_hs = bus.data_valid && bus.in_ready;
    assign beat  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            lane_buf <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        lane_buf <= bus.data_in;
                        idx      <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (beat) begin
                        if (last_lane) begin
                            idx <= '0;
                            // in_hs can only be true here when preload is built in
                            if (in_hs) lane_buf <= bus.data_in;
                            else       state    <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_unpack_unit.sv
// Random + directed scoreboard bench for data_unpack_unit (lane queue reference model).
module tb_data_unpack_unit;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int DW = 2 * W * D;
`ifdef DATA_UNPACK_PRELOAD_EN
    localparam bit PRELOAD = 1'b1;
`else
    localparam bit PRELOAD = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        bit           last;
    } pair_t;

    logic clk = 1'b0;
    logic rst;
    logic en;

    data_unpack_unit_if #(.WIDTH(W), .DEPTH(D)) bus ();

    data_unpack_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    always #5 clk = ~clk;

    pair_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    bit    acc_ir   = 1'b0;
    bit    zero_out = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: predicts control outputs from the lane queue, compares, then retires beats.
    initial begin
        forever begin
            bit exp_ir, exp_ov;
            @(negedge clk);
            exp_ov = en && !rst && (exp_q.size() > 0);
            exp_ir = en && !rst && ((exp_q.size() == 0) ||
                     (PRELOAD && exp_q.size() > 0 && exp_q[0].last && bus.out_ready));
            chk("in_ready",  {63'd0, bus.in_ready},  {63'd0, exp_ir});
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_ov});
            chk("out_last",  {63'd0, bus.out_last},  {63'd0, exp_ov && exp_q[0].last});
            if (exp_ov) begin
                chk("data_out1", {56'd0, bus.data_out1}, {56'd0, exp_q[0].d1});
                chk("data_out2", {56'd0, bus.data_out2}, {56'd0, exp_q[0].d2});
            end else if (zero_out) begin
                chk("reset_out1", {56'd0, bus.data_out1}, 64'd0);
                chk("reset_out2", {56'd0, bus.data_out2}, 64'd0);
            end
            acc_ir = exp_ir;
            if (rst) begin
                exp_q.delete();
                zero_out = 1'b1;
            end else if (exp_ov && bus.out_ready) begin
                void'(exp_q.pop_front());
            end
        end
    end

    // One stimulus cycle; if the offered word will be taken, its lanes join the scoreboard.
    task automatic cyc(input logic r, input logic e, input logic dv,
                       input logic [DW-1:0] d, input logic orr);
        @(posedge clk);
        #1;
        rst = r; en = e; bus.data_valid = dv; bus.data_in = d; bus.out_ready = orr;
        @(negedge clk);
        #2;
        if (dv && acc_ir) begin
            for (int i = 0; i < D; i++) begin
                pair_t p;
                p.d1   = d[2*W*i +: W];
                p.d2   = d[2*W*i + W +: W];
                p.last = (i == D - 1);
                exp_q.push_back(p);
            end
            zero_out = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom()};
    endfunction

    logic [DW-1:0] w0;

    initial begin
        rst = 1'b1; en = 1'b0;
        bus.data_valid = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;
        w0 = 64'h0807_0605_0403_0201;

        repeat (2) cyc(1, 0, 0, '0, 0);
        // Basic unpack with out_ready held high
        cyc(0, 1, 1, w0, 1);
        repeat (6) cyc(0, 1, 0, rnd_word(), 1);
        // Back-pressure for three cycles on lane 1
        cyc(0, 1, 1, w0, 1);
        cyc(0, 1, 0, '0, 1);
        repeat (3) cyc(0, 1, 0, '0, 0);
        repeat (5) cyc(0, 1, 0, '0, 1);
        // Back-to-back words with data_valid held high
        repeat (12) cyc(0, 1, 1, rnd_word(), 1);
        repeat (3) cyc(0, 1, 0, '0, 1);
        // Enable dropped for two cycles after lane 1
        cyc(0, 1, 1, w0, 1);
        repeat (2) cyc(0, 1, 0, '0, 1);
        repeat (2) cyc(0, 0, 1, rnd_word(), 1);
        repeat (4) cyc(0, 1, 0, '0, 1);
        // Reset during lane 2, then a fresh word
        cyc(0, 1, 1, w0, 1);
        repeat (2) cyc(0, 1, 0, '0, 1);
        cyc(1, 1, 1, rnd_word(), 1);
        cyc(0, 1, 0, '0, 0);
        cyc(0, 1, 1, rnd_word(), 1);
        repeat (5) cyc(0, 1, 0, '0, 1);
        // data_valid pulse in the middle of a word
        cyc(0, 1, 1, w0, 1);
        cyc(0, 1, 0, '0, 0);
        cyc(0, 1, 1, rnd_word(), 0);
        repeat (6) cyc(0, 1, 0, '0, 1);

        // Randomized phases: {en%, out_ready%, data_valid%}
        for (int ph = 0; ph < 4; ph++) begin
            int pe, po, pd;
            case (ph)
                0: begin pe = 100; po = 100; pd = 100; end
                1: begin pe = 100; po = 60;  pd = 50;  end
                2: begin pe = 80;  po = 80;  pd = 70;  end
                default: begin pe = 90; po = 100; pd = 30; end
            endcase
            for (int c = 0; c < 400; c++) begin
                cyc($urandom_range(59) == 0,
                    $urandom_range(99) < pe,
                    $urandom_range(99) < pd,
                    rnd_word(),
                    $urandom_range(99) < po);
            end
        end
        repeat (2) cyc(0, 1, 0, '0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
